// File: rtl/command_issuer_if.sv
// Signal bundle between the command issuer (master) and its host/executor environment (slave).
interface command_issuer_if #(
    parameter int DATA_W    = 8,
    parameter int EXIT_W    = 8,
    parameter int OUT_DEPTH = 64
);
    localparam int LEN_W = $clog2(OUT_DEPTH) + 1;

    logic              start;
    logic              host_arg_valid;
    logic              host_arg_ready;
    logic [DATA_W-1:0] host_arg_data;
    logic              host_arg_last;
    logic              host_arg_eoc;
    logic              ex_arg_valid;
    logic              ex_arg_ready;
    logic [DATA_W-1:0] ex_arg_data;
    logic              ex_arg_last;
    logic              ex_arg_eoc;
    logic              ex_out_valid;
    logic              ex_out_ready;
    logic [DATA_W-1:0] ex_out_data;
    logic              ex_done;
    logic [EXIT_W-1:0] ex_exit_code;
    logic              ex_abort;
    logic              busy;
    logic              result_valid;
    logic              result_ack;
    logic [EXIT_W-1:0] exit_code;
    logic [LEN_W-1:0]  out_len;
    logic              truncated;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;

    modport master (
        input  start, host_arg_valid, host_arg_data, host_arg_last, host_arg_eoc,
               ex_arg_ready, ex_out_valid, ex_out_data, ex_done, ex_exit_code,
               result_ack, rd_ready,
        output host_arg_ready, ex_arg_valid, ex_arg_data, ex_arg_last, ex_arg_eoc,
               ex_out_ready, ex_abort, busy, result_valid, exit_code, out_len,
               truncated, rd_valid, rd_data
    );

    modport slave (
        output start, host_arg_valid, host_arg_data, host_arg_last, host_arg_eoc,
               ex_arg_ready, ex_out_valid, ex_out_data, ex_done, ex_exit_code,
               result_ack, rd_ready,
        input  host_arg_ready, ex_arg_valid, ex_arg_data, ex_arg_last, ex_arg_eoc,
               ex_out_ready, ex_abort, busy, result_valid, exit_code, out_len,
               truncated, rd_valid, rd_data
    );
endinterface

// File: rtl/command_issuer.sv
// Streams a host command to an executor, buffers its output in a FIFO and reports
// the exit code; rejects over-long commands locally and times out a silent executor.
module command_issuer #(
    parameter int DATA_W    = 8,
    parameter int MAX_ARGS  = 16,
    parameter int OUT_DEPTH = 64,
    parameter int EXIT_W    = 8,
    parameter int TIMEOUT   = 1024
) (
    input logic              clk,
    input logic              rst,
    command_issuer_if.master bus
);
    localparam int AW    = $clog2(OUT_DEPTH);
    localparam int LEN_W = AW + 1;
    localparam int CNT_W = $clog2(MAX_ARGS + 2);
    localparam int TMR_W = $clog2(TIMEOUT);

    localparam logic [LEN_W-1:0]  DEPTH_VAL    = LEN_W'(OUT_DEPTH);
    localparam logic [CNT_W-1:0]  ARG_LIMIT    = CNT_W'(MAX_ARGS);
    localparam logic [TMR_W-1:0]  TMR_LAST     = TMR_W'(TIMEOUT - 1);
    localparam logic [EXIT_W-1:0] EXIT_REJECT  = EXIT_W'(1);
    localparam logic [EXIT_W-1:0] EXIT_TIMEOUT = EXIT_W'(124);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        DRAIN,
        WAIT,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  arg_cnt_q, arg_cnt_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [EXIT_W-1:0] exit_code_q, exit_code_d;
    logic [LEN_W-1:0]  out_len_q, out_len_d;
    logic              truncated_q, truncated_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0]  fifo_cnt_q, fifo_cnt_d;
    logic [DATA_W-1:0] fifo_mem [OUT_DEPTH];

    logic in_send;
    logic in_drain;
    logic in_wait;
    logic host_hs;
    logic tok_end;
    logic over_limit;
    logic timeout_hit;
    logic fifo_full;
    logic fifo_nonempty;
    logic pop;
    logic beat;
    logic push;
    logic drop;

    always_comb begin
        in_send       = (state_q == SEND);
        in_drain      = (state_q == DRAIN);
        in_wait       = (state_q == WAIT);
        host_hs       = bus.host_arg_valid && (in_send ? bus.ex_arg_ready : in_drain);
        tok_end       = bus.host_arg_last || bus.host_arg_eoc;
        over_limit    = in_send && host_hs && tok_end && (arg_cnt_q == ARG_LIMIT);
        timeout_hit   = in_wait && (timer_q == TMR_LAST) && !bus.ex_done;
        fifo_full     = (fifo_cnt_q == DEPTH_VAL);
        fifo_nonempty = (fifo_cnt_q != '0);
        pop           = fifo_nonempty && bus.rd_ready;
        beat          = in_wait && bus.ex_out_valid;
        // A pop in the same cycle frees a slot, so a full FIFO still accepts the beat.
        push          = beat && (!fifo_full || pop);
        drop          = beat && !push;
    end

    assign bus.ex_arg_valid   = in_send && bus.host_arg_valid;
    assign bus.host_arg_ready = in_send ? bus.ex_arg_ready : in_drain;
    assign bus.ex_arg_data    = in_send ? bus.host_arg_data : '0;
    assign bus.ex_arg_last    = in_send && bus.host_arg_last;
    assign bus.ex_arg_eoc     = in_send && bus.host_arg_eoc;
    assign bus.ex_out_ready   = in_wait;
    assign bus.ex_abort       = over_limit || timeout_hit;
    assign bus.busy           = (state_q != IDLE);
    assign bus.result_valid   = (state_q == DONE);
    assign bus.exit_code      = exit_code_q;
    assign bus.out_len        = out_len_q;
    assign bus.truncated      = truncated_q;
    assign bus.rd_valid       = fifo_nonempty;
    assign bus.rd_data        = fifo_nonempty ? fifo_mem[rd_ptr_q] : '0;

    always_comb begin
        state_d     = state_q;
        arg_cnt_d   = arg_cnt_q;
        timer_d     = timer_q;
        exit_code_d = exit_code_q;
        out_len_d   = out_len_q;
        truncated_d = truncated_q;
        wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + LEN_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - LEN_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

        case (state_q)
            IDLE: begin
                // Results stay visible after the ack; everything is cleared only when a new command starts.
                if (bus.start) begin
                    state_d     = SEND;
                    arg_cnt_d   = '0;
                    timer_d     = '0;
                    exit_code_d = '0;
                    out_len_d   = '0;
                    truncated_d = 1'b0;
                    wr_ptr_d    = '0;
                    rd_ptr_d    = '0;
                    fifo_cnt_d  = '0;
                end
            end
            SEND: begin
                if (host_hs && tok_end) begin
                    arg_cnt_d = arg_cnt_q + CNT_W'(1);
                    if (over_limit) begin
                        if (bus.host_arg_eoc) begin
                            state_d     = DONE;
                            exit_code_d = EXIT_REJECT;
                            out_len_d   = '0;
                        end else begin
                            state_d = DRAIN;
                        end
                    end else if (bus.host_arg_eoc) begin
                        state_d = WAIT;
                    end
                end
            end
            DRAIN: begin
                if (host_hs && bus.host_arg_eoc) begin
                    state_d     = DONE;
                    exit_code_d = EXIT_REJECT;
                    out_len_d   = '0;
                end
            end
            WAIT: begin
                if (push && (out_len_q != DEPTH_VAL)) begin
                    out_len_d = out_len_q + LEN_W'(1);
                end
                if (drop) begin
                    truncated_d = 1'b1;
                end
                timer_d = beat ? '0 : timer_q + TMR_W'(1);
                if (bus.ex_done) begin
                    state_d     = DONE;
                    exit_code_d = bus.ex_exit_code;
                end else if (timeout_hit) begin
                    state_d     = DONE;
                    exit_code_d = EXIT_TIMEOUT;
                end
            end
            DONE: begin
                if (bus.result_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            arg_cnt_q   <= '0;
            timer_q     <= '0;
            exit_code_q <= '0;
            out_len_q   <= '0;
            truncated_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            arg_cnt_q   <= arg_cnt_d;
            timer_q     <= timer_d;
            exit_code_q <= exit_code_d;
            out_len_q   <= out_len_d;
            truncated_q <= truncated_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
        end
    end

    // Storage needs no reset: the read port is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= bus.ex_out_data;
        end
    end
endmodule
